// File: rtl/shift_arbiter_pkg.sv
// Shared types and constants for the shift arbiter and its shifter.
package shift_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    typedef enum logic [1:0] {
        MODE_SLL = 2'd0,
        MODE_SRL = 2'd1,
        MODE_SRA = 2'd2
    } shift_mode_e;

    // Left shifts ignore the logical flag; right shifts pick fill by it.
    function automatic shift_mode_e mode_of(input logic left, input logic log_f);
        if (left) begin
            return MODE_SLL;
        end
        return log_f ? MODE_SRL : MODE_SRA;
    endfunction

endpackage

// File: rtl/ShiftLR.sv
// Combinational left/right shifter; output is zero while not enabled.
module ShiftLR
    import shift_arbiter_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic        en_i,
    input  logic [W-1:0] data_i,
    input  logic [4:0]  amt_i,
    input  shift_mode_e mode_i,
    output logic [W-1:0] data_o
);

    // Select shift flavour when enabled.
    always_comb begin
        data_o = '0;
        if (en_i) begin
            case (mode_i)
                MODE_SLL: data_o = data_i << amt_i;
                MODE_SRL: data_o = data_i >> amt_i;
                MODE_SRA: data_o = $unsigned($signed(data_i) >>> amt_i);
                default:  data_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end sharing one shifter; one op per 2 cycles.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int unsigned W    = 32,
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [W-1:0]    a_data,
    input  logic [4:0]      a_amt,
    input  logic            a_left,
    input  logic            a_log,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [W-1:0]    b_data,
    input  logic [4:0]      b_amt,
    input  logic            b_left,
    input  logic            b_log,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            resp_id,
    output logic [W-1:0]    resp_data,
    output logic            busy,
    output logic [CNTW-1:0] op_count
);

    state_e      state_q, state_d;
    logic        rr_q, rr_d;          // 0: favour A, 1: favour B
    logic [W-1:0] op_data_q, op_data_d;
    logic [4:0]  op_amt_q, op_amt_d;
    shift_mode_e op_mode_q, op_mode_d;
    logic        op_id_q, op_id_d;
    logic [W-1:0] resp_data_q, resp_data_d;
    logic        resp_id_q, resp_id_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic        grant_ok;
    logic        shift_en;
    logic [W-1:0] shift_out;

    ShiftLR #(.W(W)) u_shift (
        .en_i   (shift_en),
        .data_i (op_data_q),
        .amt_i  (op_amt_q),
        .mode_i (op_mode_q),
        .data_o (shift_out)
    );

    // Arbitration: ready depends on valid only through the winner choice.
    always_comb begin
        grant_ok = (state_q == ST_IDLE) || ((state_q == ST_RESP) && resp_ready);
        a_ready  = grant_ok && a_valid && (!b_valid || !rr_q);
        b_ready  = grant_ok && b_valid && (!a_valid || rr_q);
    end

    // Next-state, operand capture, response capture and counter.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        op_data_d   = op_data_q;
        op_amt_d    = op_amt_q;
        op_mode_d   = op_mode_q;
        op_id_d     = op_id_q;
        resp_data_d = resp_data_q;
        resp_id_d   = resp_id_q;
        cnt_d       = cnt_q;
        shift_en    = 1'b0;

        case (state_q)
            ST_EXEC: begin
                shift_en    = 1'b1;
                resp_data_d = shift_out;
                resp_id_d   = op_id_q;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase

        if (a_ready) begin
            op_data_d = a_data;
            op_amt_d  = a_amt;
            op_mode_d = mode_of(a_left, a_log);
            op_id_d   = ID_A;
            rr_d      = 1'b1;
            state_d   = ST_EXEC;
        end else if (b_ready) begin
            op_data_d = b_data;
            op_amt_d  = b_amt;
            op_mode_d = mode_of(b_left, b_log);
            op_id_d   = ID_B;
            rr_d      = 1'b0;
            state_d   = ST_EXEC;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_q        <= 1'b0;
            op_data_q   <= '0;
            op_amt_q    <= '0;
            op_mode_q   <= MODE_SLL;
            op_id_q     <= ID_A;
            resp_data_q <= '0;
            resp_id_q   <= ID_A;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            op_data_q   <= op_data_d;
            op_amt_q    <= op_amt_d;
            op_mode_q   <= op_mode_d;
            op_id_q     <= op_id_d;
            resp_data_q <= resp_data_d;
            resp_id_q   <= resp_id_d;
            cnt_q       <= cnt_d;
        end
    end

    assign resp_valid = (state_q == ST_RESP);
    assign busy       = (state_q != ST_IDLE);
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
    assign op_count   = cnt_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Randomized and directed checks of shift_arbiter against a transaction-queue model.
module tb_shift_arbiter;

    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0, a_left = 1'b0, a_log = 1'b0;
    logic        b_valid = 1'b0, b_left = 1'b0, b_log = 1'b0;
    logic [31:0] a_data = '0, b_data = '0;
    logic [4:0]  a_amt = '0, b_amt = '0;
    logic        resp_ready = 1'b0;
    logic        a_ready, b_ready, resp_valid, resp_id, busy;
    logic [31:0] resp_data;
    logic [CW-1:0] op_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          t_ready;
        logic [31:0] data;
        logic        id;
    } exp_t;

    exp_t q[$];
    int   m_cnt    = 0;
    bit   m_last_b = 1'b1;

    shift_arbiter #(.W(32), .CNTW(CW)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_amt(a_amt),
        .a_left(a_left), .a_log(a_log),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_amt(b_amt),
        .b_left(b_left), .b_log(b_log),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Shift expressed as integer arithmetic: multiply / floor-divide by 2^amt.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int amt,
                                              input bit left, input bit lg);
        logic [63:0] p;
        logic [63:0] prod;
        p = 64'd1 << amt;
        if (left) begin
            prod = {32'd0, d} * p;
            return prod[31:0];
        end
        if (lg || !d[31]) begin
            return d / p[31:0];
        end
        return ~((~d) / p[31:0]);
    endfunction

    task automatic model_reset();
        q.delete();
        m_cnt    = 0;
        m_last_b = 1'b1;
    endtask

    task automatic check_reset();
        check_eq("rst_a_ready", {31'd0, a_ready}, 32'd0);
        check_eq("rst_b_ready", {31'd0, b_ready}, 32'd0);
        check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_resp_data", resp_data, 32'd0);
        check_eq("rst_resp_id", {31'd0, resp_id}, 32'd0);
        check_eq("rst_op_count", {27'd0, op_count}, 32'd0);
    endtask

    // One cycle: check outputs at negedge against the model, advance the model.
    task automatic step();
        bit   exp_v, slot, win_a, win_b;
        exp_t e;
        @(negedge clk);
        exp_v = (q.size() > 0) && (cyc >= q[0].t_ready);
        slot  = (q.size() == 0) || (exp_v && resp_ready);
        win_a = 1'b0;
        win_b = 1'b0;
        if (slot) begin
            if (a_valid && b_valid) begin
                win_a = m_last_b;
                win_b = !m_last_b;
            end else begin
                win_a = a_valid;
                win_b = b_valid;
            end
        end
        check_eq("a_ready", {31'd0, a_ready}, {31'd0, win_a});
        check_eq("b_ready", {31'd0, b_ready}, {31'd0, win_b});
        check_eq("resp_valid", {31'd0, resp_valid}, {31'd0, exp_v});
        check_eq("busy", {31'd0, busy}, {31'd0, q.size() > 0});
        check_eq("op_count", {27'd0, op_count}, m_cnt);
        if (exp_v) begin
            check_eq("resp_data", resp_data, q[0].data);
            check_eq("resp_id", {31'd0, resp_id}, {31'd0, q[0].id});
        end
        if (exp_v && resp_ready) begin
            void'(q.pop_front());
            if (m_cnt < CMAX) m_cnt++;
        end
        if (win_a) begin
            e.t_ready = cyc + 2;
            e.data    = ref_shift(a_data, int'(a_amt), a_left, a_log);
            e.id      = 1'b0;
            q.push_back(e);
            m_last_b  = 1'b0;
        end else if (win_b) begin
            e.t_ready = cyc + 2;
            e.data    = ref_shift(b_data, int'(b_amt), b_left, b_log);
            e.id      = 1'b1;
            q.push_back(e);
            m_last_b  = 1'b1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input bit v, input logic [31:0] d, input logic [4:0] amt,
                           input bit l, input bit lg);
        a_valid = v; a_data = d; a_amt = amt; a_left = l; a_log = lg;
    endtask

    task automatic drive_b(input bit v, input logic [31:0] d, input logic [4:0] amt,
                           input bit l, input bit lg);
        b_valid = v; b_data = d; b_amt = amt; b_left = l; b_log = lg;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single A arithmetic right shift.
        resp_ready = 1'b1;
        drive_a(1, 32'hF000_0001, 5'd4, 0, 0);
        step();
        drive_a(0, '0, '0, 0, 0);
        repeat (3) step();

        // B sign-fill boundary, logical then arithmetic.
        drive_b(1, 32'h8000_0000, 5'd31, 0, 1);
        step();
        drive_b(0, '0, '0, 0, 0);
        repeat (3) step();
        drive_b(1, 32'h8000_0000, 5'd31, 0, 0);
        step();
        drive_b(0, '0, '0, 0, 0);
        repeat (3) step();

        // Amount zero, and left shift independent of logical flag.
        drive_a(1, 32'hDEAD_BEEF, 5'd0, 0, 0);
        step();
        drive_a(1, 32'h8765_4321, 5'd8, 1, 0);
        step();
        drive_a(1, 32'h8765_4321, 5'd8, 1, 1);
        repeat (3) step();
        drive_a(0, '0, '0, 0, 0);
        repeat (2) step();

        // Both requesters continuously valid: alternating grants.
        for (int i = 0; i < 12; i++) begin
            drive_a(1, $urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
            drive_b(1, $urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
            step();
        end

        // Consumer stalls in RESP: everything must hold.
        resp_ready = 1'b0;
        repeat (7) step();
        resp_ready = 1'b1;
        repeat (2) step();
        drive_a(0, '0, '0, 0, 0);
        drive_b(0, '0, '0, 0, 0);
        repeat (3) step();

        // Reset during EXEC discards the operation.
        drive_a(1, 32'h1234_5678, 5'd3, 0, 1);
        step();
        drive_a(0, '0, '0, 0, 0);
        rst = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1;
        check_reset();
        rst = 1'b0;
        drive_b(1, 32'h0000_00F0, 5'd4, 1, 0);
        step();
        drive_b(0, '0, '0, 0, 0);
        repeat (3) step();

        // Random traffic; long enough to saturate the counter.
        for (int i = 0; i < 600; i++) begin
            drive_a(1'($urandom_range(0, 99) < 60), $urandom, 5'($urandom_range(0, 31)),
                    1'($urandom), 1'($urandom));
            drive_b(1'($urandom_range(0, 99) < 60), $urandom, 5'($urandom_range(0, 31)),
                    1'($urandom), 1'($urandom));
            resp_ready = ($urandom_range(0, 99) < 70);
            step();
        end
        check_eq("op_count_saturated", {27'd0, op_count}, CMAX);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter: W, default 32, data width of the shared shifter.
REQ-002 Parameter: CNTW, default 16, width of the completed-operation counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 a_valid  input  1  requester A has an operation.
REQ-006 a_ready  output  1  requester A operation accepted this cycle.
REQ-007 a_data, a_amt, a_left, a_log  input  W/5/1/1  requester A operand, shift amount, direction, logical flag.
REQ-008 b_valid, b_ready, b_data, b_amt, b_left, b_log  same as A  requester B.
REQ-009 resp_valid  output  1  result available.
REQ-010 resp_ready  input  1  consumer accepts result.
REQ-011 resp_id  output  1  requester of the result: 0=A, 1=B.
REQ-012 resp_data  output  W  shifted result.
REQ-013 busy  output  1  high in any state except IDLE.
REQ-014 op_count  output  CNTW  completed operations, saturating.

Function
REQ-015 States: IDLE, EXEC, RESP.
REQ-016 Handshake: a request is accepted on a cycle when valid and ready are both high; ready depends on valid only through arbitration, never the reverse.
REQ-017 Grant allowed in IDLE, or in RESP on a cycle with resp_ready high.
REQ-018 Arbitration: round-robin; one valid requester wins outright; both valid, winner is the one not granted last; pointer initialises to favour A.
REQ-019 Accept captures data, amt, left, log and id into operand registers; next state EXEC.
REQ-020 EXEC: shifter EN high for exactly this cycle; left=1 logical left shift, left=0/log=1 logical right, left=0/log=0 arithmetic right; EXEC captures shifter output into resp_data; next state RESP.
REQ-021 left=1 gives an identical result for log=0 and log=1.
REQ-022 RESP: resp_valid high; resp_data and resp_id stable until the resp handshake.
REQ-023 RESP with resp_ready high: op_count increments; next state EXEC if a grant occurs that cycle, else IDLE.
REQ-024 Latency: accept at cycle t gives resp_valid at t+2; back-to-back throughput is one operation per 2 cycles.
REQ-025 Amount 0 returns the operand unchanged; amount 31 fully exercises sign fill.
REQ-026 op_count saturates at all-ones; it does not wrap.
REQ-027 Requester valid dropping before acceptance has no effect.
REQ-028 At most one of a_ready and b_ready is high per cycle.

Reset
REQ-029 On rst: state IDLE; a_ready, b_ready, resp_valid and busy low; resp_data, resp_id and op_count zero; round-robin pointer favours A; shifter EN low.
REQ-030 rst asserted mid-operation discards the in-flight operation without producing a response.

Structure
REQ-031 Shared package holds the state enum, requester-id constants (ID_A=0, ID_B=1) and the shift-mode encodings.
REQ-032 Sole sub-module: one ShiftLR instance, EN driven only by the EXEC state.

Verification
REQ-033 Only A valid, data=0xF0000001, amt=4, left=0, log=0 -> resp_data=0xFF000000, resp_id=0, resp_valid two cycles after accept.
REQ-034 A and B valid continuously, resp_ready=1 -> grants alternate A,B,A,B starting with A; one response every 2 cycles.
REQ-035 B data=0x80000000, amt=31, left=0: log=1 -> 0x00000001; log=0 -> 0xFFFFFFFF.
REQ-036 Hold resp_ready=0 for 5 cycles in RESP -> resp_data and resp_id stable, a_ready and b_ready low, op_count unchanged.
REQ-037 rst pulsed during EXEC -> no resp_valid, all outputs at reset values; next request serviced normally.
REQ-038 Force op_count to all-ones minus one, complete 3 ops -> op_count holds all-ones.
